// File: rtl/tc_product_round_sat.sv
// tc_product_round_sat: adds product and offset, rounds half-up, shifts and saturates, through a 2-stage valid/ready pipeline
module tc_product_round_sat #(
  parameter int IN_W  = 31,
  parameter int OFF_W = 31,
  parameter int SHIFT = 14,
  parameter int OUT_W = 14,
  parameter int TAG_W = 7
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_prod,
  input  logic [OFF_W-1:0] in_off,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      ovf_count
);
  localparam int W  = (IN_W > OFF_W ? IN_W : OFF_W) + 1;
  localparam int SW = W + 1;
  localparam logic signed [SW-1:0] C_RND = SW'(longint'(1) <<< (SHIFT - 1));
  localparam logic signed [SW-1:0] C_MAX = SW'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] C_MIN = SW'(-(longint'(1) <<< (OUT_W - 1)));

  logic                    r_v1, r_v2, r_ovf;
  logic signed [SW-1:0]    r_sum;
  logic [TAG_W-1:0]        r_tag1, r_tag2;
  logic [OUT_W-1:0]        r_data;
  logic [15:0]             r_cnt;
  logic                    w_s1_ld, w_s2_ld, w_sat_hi, w_sat_lo;
  logic signed [SW-1:0]    w_sum, w_q;
  logic [OUT_W-1:0]        w_data;

  // Extra headroom bit keeps the rounded sum from ever wrapping.
  assign w_sum    = {{(SW-IN_W){in_prod[IN_W-1]}}, in_prod}
                  + {{(SW-OFF_W){in_off[OFF_W-1]}}, in_off} + C_RND;
  assign w_q      = r_sum >>> SHIFT;
  assign w_sat_hi = w_q > C_MAX;
  assign w_sat_lo = w_q < C_MIN;
  assign w_data   = w_sat_hi ? C_MAX[OUT_W-1:0] : w_sat_lo ? C_MIN[OUT_W-1:0] : w_q[OUT_W-1:0];
  assign w_s2_ld  = !r_v2 || out_ready;
  assign w_s1_ld  = !r_v1 || w_s2_ld;
  assign in_ready  = w_s1_ld;
  assign out_valid = r_v2;
  assign out_data  = r_data;
  assign out_ovf   = r_ovf;
  assign out_tag   = r_tag2;
  assign ovf_count = r_cnt;

  // Stage 1: capture the rounded sum and tag whenever the stage is free to advance
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_v1   <= 1'b0;
      r_sum  <= '0;
      r_tag1 <= '0;
    end else if (w_s1_ld) begin
      r_v1   <= in_valid;
      r_sum  <= w_sum;
      r_tag1 <= in_tag;
    end
  end

  // Stage 2: shift, saturate and hold the result until downstream accepts it
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_v2   <= 1'b0;
      r_data <= '0;
      r_ovf  <= 1'b0;
      r_tag2 <= '0;
    end else if (w_s2_ld) begin
      r_v2   <= r_v1;
      r_data <= w_data;
      r_ovf  <= w_sat_hi || w_sat_lo;
      r_tag2 <= r_tag1;
    end
  end

  // Count delivered overflow beats, sticking at the maximum
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_cnt <= '0;
    else if (r_v2 && out_ready && r_ovf && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  end
endmodule

// File: tb/tb_tc_product_round_sat.sv
// tb_tc_product_round_sat: vector table plus scoreboard checks of rounding, saturation, flow control and reset
module tb_tc_product_round_sat;
  logic        ap_clk = 0, ap_rst = 1, in_valid = 0, out_ready = 1;
  logic [30:0] in_prod = 0, in_off = 0;
  logic [6:0]  in_tag = 0;
  logic        in_ready, out_valid, out_ovf;
  logic [13:0] out_data;
  logic [6:0]  out_tag;
  logic [15:0] ovf_count;

  tc_product_round_sat dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_off(in_off), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .out_tag(out_tag),
    .ovf_count(ovf_count)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {int d; bit v; int t;} exp_t;
  typedef struct {longint p; longint o; int d; bit v; int c;} vec_t;
  exp_t   sb[$];
  int     total = 0, bad = 0, n_out = 0;
  longint cyc = 0, last_out_cyc = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string n, input longint a, input longint e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask

  // Reference: floor((p+o)/2^14 + 1/2) via integer division, then clamp to 14-bit signed.
  function automatic void model(input longint p, input longint o, output int d, output bit v);
    longint s, q;
    s = p + o + 8192;
    q = s / 16384;
    if (s < 0 && s % 16384 != 0) q = q - 1;
    v = (q > 8191) || (q < -8192);
    d = q > 8191 ? 8191 : q < -8192 ? -8192 : int'(q);
  endfunction

  // Output monitor: each delivered beat must match the oldest expectation.
  always @(negedge ap_clk) begin
    exp_t e;
    if (!ap_rst && out_valid && out_ready) begin
      n_out++;
      last_out_cyc = cyc;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious beat: got tag %0d want no beat", out_tag);
      end else begin
        e = sb.pop_front();
        chk("data", longint'($signed(out_data)), e.d);
        chk("ovf", out_ovf, e.v);
        chk("tag", out_tag, e.t);
      end
    end
  end

  task automatic send(input longint p, input longint o, input int t, input int d, input bit v);
    bit ok = 0;
    in_prod = 31'(p);
    in_off = 31'(o);
    in_tag = 7'(t);
    in_valid = 1;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge ap_clk);
      ok = in_ready;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept timeout tag %0d: got in_ready 0 want 1", t);
    end else sb.push_back('{d, v, t});
    @(posedge ap_clk);
    #1 in_valid = 0;
  endtask

  task automatic send_m(input longint p, input longint o, input int t);
    int d;
    bit v;
    model(p, o, d, v);
    send(p, o, t, d, v);
  endtask

  task automatic drain(input int target);
    for (int k = 0; k < 200 && n_out < target; k++) @(posedge ap_clk);
    #1 chk("drain count", n_out, target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv[13];
    logic [30:0] rp, ro;
    int          base;
    longint      rel;
    tv = '{
      '{16384, 0, 1, 0, 0}, '{8191, 0, 0, 0, 0}, '{8192, 0, 1, 0, 0},
      '{-8192, 0, 0, 0, 0}, '{-8193, 0, -1, 0, 0}, '{24576, -8192, 1, 0, 0},
      '{-24576, 0, -1, 0, 0}, '{134201344, 0, 8191, 0, 0}, '{134209536, 0, 8191, 1, 1},
      '{-134225920, 0, -8192, 0, 1}, '{-134225921, 0, -8192, 1, 2},
      '{1073741823, 1073741823, 8191, 1, 3}, '{-1073741824, -1073741824, -8192, 1, 4}
    };
    repeat (2) @(posedge ap_clk);
    #1 chk("reset out_valid", out_valid, 0);
    chk("reset ovf_count", ovf_count, 0);
    chk("reset out_data", out_data, 0);
    ap_rst = 0;
    #1 chk("reset in_ready", in_ready, 1);
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      send(tv[i].p, tv[i].o, i, tv[i].d, tv[i].v);
      chk("latency early", out_valid, 0);
      @(posedge ap_clk);
      #1 chk("latency 2", out_valid, 1);
      @(posedge ap_clk);
      #1 chk("ovf_count", ovf_count, tv[i].c);
    end
    base = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rp = 31'($urandom);
          ro = 31'($urandom_range(0, 65535)) - 31'd32768;
          send_m(longint'($signed(rp)), longint'($signed(ro)), i);
        end
      end
      begin
        repeat (4) @(posedge ap_clk);
        #1 out_ready = 0;
        repeat (5) begin
          @(negedge ap_clk);
          chk("stall in_ready", in_ready, 0);
          chk("stall out_valid", out_valid, 1);
          chk("stall data", longint'($signed(out_data)), sb[0].d);
          chk("stall tag", out_tag, sb[0].t);
        end
        @(posedge ap_clk);
        #1 out_ready = 1;
        rel = cyc;
      end
    join
    drain(base + 10);
    chk("stream rate", last_out_cyc - rel, 7);
    chk("stream leftovers", sb.size(), 0);
    send(16384, 0, 20, 1, 0);
    send(-16384, 0, 21, -1, 0);
    chk("pre-reset out_valid", out_valid, 1);
    #1 ap_rst = 1;
    #1 chk("async out_valid", out_valid, 0);
    chk("async ovf_count", ovf_count, 0);
    sb.delete();
    #1 ap_rst = 0;
    repeat (4) begin
      @(negedge ap_clk);
      chk("no stale beat", out_valid, 0);
    end
    @(posedge ap_clk);
    #1 send(16384, 0, 30, 1, 0);
    chk("post-reset early", out_valid, 0);
    @(posedge ap_clk);
    #1 chk("post-reset latency", out_valid, 1);
    @(posedge ap_clk);
    #1 chk("post-reset count", ovf_count, 0);
    base = n_out;
    for (int i = 0; i < 65540; i++) send(1073741823, 1073741823, i % 128, 8191, 1);
    drain(base + 65540);
    chk("ovf_count saturate", ovf_count, 65535);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
